// File: rtl/version_reporter.sv
// Build-version reporter: streams a 13-byte version/timestamp frame over a
// valid/ready byte interface on request or on a free-running auto-report timer.

package version_pkg;
  localparam logic [7:0]  C_VERSION_MAJOR  = 8'h01;
  localparam logic [7:0]  C_VERSION_MINOR  = 8'h00;
  localparam logic [7:0]  C_VERSION_PATCH  = 8'h00;
  localparam logic [7:0]  C_VERSION_BUILD  = 8'h2A;
  localparam logic [15:0] C_VERSION_YEAR   = 16'h2024;
  localparam logic [7:0]  C_VERSION_MONTH  = 8'h06;
  localparam logic [7:0]  C_VERSION_DAY    = 8'h15;
  localparam logic [7:0]  C_VERSION_HOUR   = 8'h12;
  localparam logic [7:0]  C_VERSION_MINUTE = 8'h30;
  localparam logic [7:0]  C_VERSION_SECOND = 8'h00;
endpackage

// Handshake: a byte moves on a rising edge where out_valid=1 and out_ready=1;
// while out_valid=1 and out_ready=0, out_data and out_valid hold their values.
module version_reporter
  import version_pkg::*;
#(
  parameter logic [31:0] AUTO_PERIOD = 32'd0,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [7:0]  VER_MAJOR   = C_VERSION_MAJOR,
  parameter logic [7:0]  VER_MINOR   = C_VERSION_MINOR,
  parameter logic [7:0]  VER_PATCH   = C_VERSION_PATCH,
  parameter logic [7:0]  VER_BUILD   = C_VERSION_BUILD,
  parameter logic [15:0] VER_YEAR    = C_VERSION_YEAR,
  parameter logic [7:0]  VER_MONTH   = C_VERSION_MONTH,
  parameter logic [7:0]  VER_DAY     = C_VERSION_DAY,
  parameter logic [7:0]  VER_HOUR    = C_VERSION_HOUR,
  parameter logic [7:0]  VER_MINUTE  = C_VERSION_MINUTE,
  parameter logic [7:0]  VER_SECOND  = C_VERSION_SECOND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [3:0] LAST_IDX = 4'd12;
  localparam logic [7:0] CHECKSUM = VER_MAJOR ^ VER_MINOR ^ VER_PATCH ^ VER_BUILD ^
                                    VER_YEAR[15:8] ^ VER_YEAR[7:0] ^ VER_MONTH ^
                                    VER_DAY ^ VER_HOUR ^ VER_MINUTE ^ VER_SECOND;

  state_t      state;
  logic [3:0]  idx;
  logic        pending;
  logic [31:0] auto_cnt;
  logic        auto_wrap;
  logic        start_req;
  logic        accept;

  function automatic logic [7:0] frame_byte(input logic [3:0] i);
    case (i)
      4'd0:    frame_byte = SYNC_BYTE;
      4'd1:    frame_byte = VER_MAJOR;
      4'd2:    frame_byte = VER_MINOR;
      4'd3:    frame_byte = VER_PATCH;
      4'd4:    frame_byte = VER_BUILD;
      4'd5:    frame_byte = VER_YEAR[15:8];
      4'd6:    frame_byte = VER_YEAR[7:0];
      4'd7:    frame_byte = VER_MONTH;
      4'd8:    frame_byte = VER_DAY;
      4'd9:    frame_byte = VER_HOUR;
      4'd10:   frame_byte = VER_MINUTE;
      4'd11:   frame_byte = VER_SECOND;
      4'd12:   frame_byte = CHECKSUM;
      default: frame_byte = 8'h00;
    endcase
  endfunction

  // The wrap flag is registered so the frame starts one cycle after the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt  <= '0;
      auto_wrap <= 1'b0;
    end else if (AUTO_PERIOD != 32'd0) begin
      auto_wrap <= (auto_cnt == AUTO_PERIOD - 32'd1);
      auto_cnt  <= (auto_cnt == AUTO_PERIOD - 32'd1) ? 32'd0 : auto_cnt + 32'd1;
    end
  end

  assign start_req = req | auto_wrap;
  assign accept    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      pending    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_req) begin
            state     <= SEND;
            busy      <= 1'b1;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= frame_byte(4'd0);
          end
        end
        SEND: begin
          if (accept && idx == LAST_IDX) begin
            frame_done <= 1'b1;
            idx        <= '0;
            pending    <= 1'b0;
            // A request seen during this frame (or right now) chains the next
            // frame with no idle gap.
            if (pending || start_req) begin
              out_data <= frame_byte(4'd0);
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_data  <= '0;
            end
          end else if (accept) begin
            idx      <= idx + 4'd1;
            out_data <= frame_byte(idx + 4'd1);
            pending  <= pending | start_req;
          end else begin
            pending <= pending | start_req;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_version_reporter.sv
// Directed bench for version_reporter: one instance with overridden fields for
// request/backpressure/collapse/reset tests, one with AUTO_PERIOD=40.
module tb_version_reporter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       frame_done;

  logic       req_a;
  logic       out_ready_a;
  logic [7:0] out_data_a;
  logic       out_valid_a;
  logic       busy_a;
  logic       frame_done_a;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_a_q[$];
  logic [7:0] frame_tbl[13];
  logic [7:0] auto_tbl[13];

  int  pos = 0;
  bit  expect_done = 1'b0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int  done_seen = 0;
  int  exp_done = 0;

  int  acyc = 0;
  int  a_starts = 0;
  bit  a_prev_valid = 1'b0;

  version_reporter #(
    .AUTO_PERIOD(32'd0), .SYNC_BYTE(8'hA5),
    .VER_MAJOR(8'h01), .VER_MINOR(8'h02), .VER_PATCH(8'h03), .VER_BUILD(8'h04),
    .VER_YEAR(16'h2025), .VER_MONTH(8'h01), .VER_DAY(8'h02), .VER_HOUR(8'h03),
    .VER_MINUTE(8'h04), .VER_SECOND(8'h06)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );

  version_reporter #(.AUTO_PERIOD(32'd40)) dut_auto (
    .clk(clk), .rst(rst), .req(req_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .busy(busy_a), .frame_done(frame_done_a)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_frame();
    for (int i = 0; i < 13; i++) exp_q.push_back(frame_tbl[i]);
    exp_done++;
  endtask

  // Leaves time at 1 unit after the edge that sampled req.
  task automatic pulse_req();
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, 8'h00);
  endtask

  // ---------------- scoreboard: main instance ----------------
  always @(negedge clk) begin
    if (rst) begin
      pos = 0;
      expect_done = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_done", frame_done, expect_done);
      if (frame_done) done_seen++;
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data", out_data, prev_data);
      end
      expect_done = 1'b0;
      if (out_valid && out_ready) begin
        check("byte_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) check($sformatf("byte%0d", pos), out_data, exp_q.pop_front());
        if (pos == 12) begin
          expect_done = 1'b1;
          pos = 0;
        end else begin
          pos++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // ---------------- scoreboard: auto-report instance ----------------
  always @(posedge clk) begin
    if (rst) begin
      acyc <= 0;
    end else begin
      if (acyc % 40 == 39)
        for (int i = 0; i < 13; i++) exp_a_q.push_back(auto_tbl[i]);
      acyc <= acyc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_a_q.delete();
      a_prev_valid = 1'b0;
      a_starts = 0;
    end else begin
      if (out_valid_a && !a_prev_valid) begin
        a_starts++;
        check("auto_start_phase", acyc % 40, 1);
      end
      if (out_valid_a && out_ready_a) begin
        check("auto_byte_expected", (exp_a_q.size() != 0), 1'b1);
        if (exp_a_q.size() != 0) check("auto_byte", out_data_a, exp_a_q.pop_front());
      end
      a_prev_valid = out_valid_a;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    int n;
    logic [7:0] cs;

    frame_tbl = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h20, 8'h25,
                  8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h03};
    auto_tbl[0]  = 8'hA5;
    auto_tbl[1]  = version_pkg::C_VERSION_MAJOR;
    auto_tbl[2]  = version_pkg::C_VERSION_MINOR;
    auto_tbl[3]  = version_pkg::C_VERSION_PATCH;
    auto_tbl[4]  = version_pkg::C_VERSION_BUILD;
    auto_tbl[5]  = version_pkg::C_VERSION_YEAR[15:8];
    auto_tbl[6]  = version_pkg::C_VERSION_YEAR[7:0];
    auto_tbl[7]  = version_pkg::C_VERSION_MONTH;
    auto_tbl[8]  = version_pkg::C_VERSION_DAY;
    auto_tbl[9]  = version_pkg::C_VERSION_HOUR;
    auto_tbl[10] = version_pkg::C_VERSION_MINUTE;
    auto_tbl[11] = version_pkg::C_VERSION_SECOND;
    cs = 8'h00;
    for (int i = 1; i < 12; i++) cs = cs ^ auto_tbl[i];
    auto_tbl[12] = cs;

    rst = 1'b1;
    req = 1'b0;
    out_ready = 1'b1;
    req_a = 1'b0;
    out_ready_a = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    check("reset_done", frame_done, 1'b0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("post_reset");

    // Single frame with out_ready held high
    push_frame();
    pulse_req();
    check("start_valid", out_valid, 1'b1);
    check("start_data", out_data, 8'hA5);
    check("start_busy", busy, 1'b1);
    wait_drain("single_drain", 40);
    repeat (2) @(posedge clk);
    #1;
    check_idle("single_end");
    check("single_done_count", done_seen, exp_done);

    // Backpressure: random out_ready
    out_ready = 1'b0;
    push_frame();
    pulse_req();
    check("bp_start_data", out_data, 8'hA5);
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1 out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("bp_drain", exp_q.size(), 0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("bp_end");
    check("bp_done_count", done_seen, exp_done);

    // Request collapse: three extra pulses mid-frame give exactly one extra frame
    push_frame();
    push_frame();
    pulse_req();
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(posedge clk);
      c++;
      #1 req = (c == 3 || c == 5 || c == 9);
    end
    req = 1'b0;
    check("collapse_len", c, 26);
    check("collapse_drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_idle("collapse_end");
    check("collapse_done_count", done_seen, exp_done);

    // Reset mid-frame at index 6
    for (int i = 0; i < 6; i++) exp_q.push_back(frame_tbl[i]);
    pulse_req();
    repeat (6) @(posedge clk);
    #1;
    check("pre_abort_data", out_data, frame_tbl[6]);
    rst = 1'b1;
    #1;
    check("abort_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_data", out_data, 8'h00);
    check("abort_consumed", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check_idle("after_abort");
    push_frame();
    pulse_req();
    check("restart_data", out_data, 8'hA5);
    wait_drain("restart_drain", 40);
    repeat (2) @(posedge clk);
    #1;
    check_idle("restart_end");
    check("restart_done_count", done_seen, exp_done);

    // Let the auto-report instance run several periods
    repeat (130) @(posedge clk);
    #1;
    check("auto_starts", (a_starts >= 3), 1'b1);
    check("auto_backlog", (exp_a_q.size() <= 13), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
